// File: rtl/frame_checker.sv
// One-pass frame self-check: streams the DUT and reference buffers, counts pixel
// mismatches, records the first one and signs the DUT frame with CRC-16/CCITT-FALSE.
module frame_checker #(
    parameter int H_ACT  = 480,
    parameter int V_ACT  = 272,
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 16,
    parameter int RD_LAT = 1
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStart,
    input  logic              iEn,
    input  logic              iMode,
    input  logic [15:0]       iExpCrc,
    output logic [ADDR_W-1:0] oAddr,
    output logic              oRdEn,
    input  logic [PIX_W-1:0]  iDutData,
    input  logic [PIX_W-1:0]  iRefData,
    output logic              oBusy,
    output logic              oDone,
    output logic              oPass,
    output logic [ADDR_W-1:0] oErrCnt,
    output logic              oFirstErrValid,
    output logic [ADDR_W-1:0] oFirstErrAddr,
    output logic [ADDR_W-1:0] oFirstErrX,
    output logic [ADDR_W-1:0] oFirstErrY,
    output logic [15:0]       oCrc
);
    localparam int                DEPTH     = H_ACT * V_ACT;
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] X_LAST    = ADDR_W'(H_ACT - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ERR_MAX   = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          drain_q, drain_d;
    logic                start_acc, rd_en;
    logic [ADDR_W-1:0]   addr_q, addr_d, x_q, x_d, y_q, y_d;
    logic                mode_q, mode_d;
    logic [15:0]         exp_q, exp_d, crc_q, crc_d;
    logic [ADDR_W-1:0]   err_q, err_d, fa_q, fa_d, fx_q, fx_d, fy_q, fy_d;
    logic                fv_q, fv_d, pass_q, pass_d;
    logic [RD_LAT-1:0]   vld_q;
    logic [ADDR_W-1:0]   pa_q [RD_LAT];
    logic [ADDR_W-1:0]   px_q [RD_LAT];
    logic [ADDR_W-1:0]   py_q [RD_LAT];

    // Whole pixel shifted in MSB-first, which equals feeding its bytes MSB-first.
    function automatic logic [15:0] crc_pix(input logic [15:0] c, input logic [PIX_W-1:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int b = PIX_W - 1; b >= 0; b--) begin
            fb = r[15] ^ d[b];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        start_acc = 1'b0;
        rd_en     = 1'b0;
        case (state_q)
            S_IDLE: if (iStart) begin
                start_acc = 1'b1;
                state_d   = S_RUN;
            end
            S_RUN: if (iEn) begin
                rd_en = 1'b1;
                if (addr_q == ADDR_LAST) begin
                    state_d = S_DRAIN;
                    drain_d = 3'(RD_LAT - 1);
                end
            end
            S_DRAIN: begin
                if (drain_q == 3'd0) state_d = S_DONE;
                else                 drain_d = drain_q - 3'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        x_d    = x_q;
        y_d    = y_q;
        mode_d = mode_q;
        exp_d  = exp_q;
        crc_d  = crc_q;
        err_d  = err_q;
        fv_d   = fv_q;
        fa_d   = fa_q;
        fx_d   = fx_q;
        fy_d   = fy_q;
        pass_d = pass_q;
        if (start_acc) begin
            addr_d = '0;
            x_d    = '0;
            y_d    = '0;
            mode_d = iMode;
            exp_d  = iExpCrc;
            crc_d  = 16'hFFFF;
            err_d  = '0;
            fv_d   = 1'b0;
            fa_d   = '0;
            fx_d   = '0;
            fy_d   = '0;
            pass_d = 1'b0;
        end else begin
            if (rd_en) begin
                addr_d = addr_q + ONE;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = y_q + ONE;
                end else begin
                    x_d = x_q + ONE;
                end
            end
            if (vld_q[RD_LAT-1]) begin
                crc_d = crc_pix(crc_q, iDutData);
                if (!mode_q && (iDutData != iRefData)) begin
                    if (err_q != ERR_MAX) err_d = err_q + ONE;
                    if (!fv_q) begin
                        fv_d = 1'b1;
                        fa_d = pa_q[RD_LAT-1];
                        fx_d = px_q[RD_LAT-1];
                        fy_d = py_q[RD_LAT-1];
                    end
                end
            end
            // Verdict uses the post-update values so the last pixel is included.
            if (state_q == S_DRAIN && drain_q == 3'd0)
                pass_d = mode_q ? (crc_d == exp_q) : (err_d == '0);
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= S_IDLE;
            drain_q <= 3'd0;
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= 1'b0;
            exp_q   <= '0;
            crc_q   <= 16'hFFFF;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fa_q    <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
            pass_q  <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pa_q[i] <= '0;
                px_q[i] <= '0;
                py_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            addr_q  <= addr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            exp_q   <= exp_d;
            crc_q   <= crc_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fa_q    <= fa_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            pass_q  <= pass_d;
            // Read-valid pipeline tracks the memory latency with its coordinates.
            vld_q[0] <= rd_en;
            pa_q[0]  <= addr_q;
            px_q[0]  <= x_q;
            py_q[0]  <= y_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                pa_q[i]  <= pa_q[i-1];
                px_q[i]  <= px_q[i-1];
                py_q[i]  <= py_q[i-1];
            end
        end
    end

    assign oAddr          = addr_q;
    assign oRdEn          = rd_en;
    assign oBusy          = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign oDone          = (state_q == S_DONE);
    assign oPass          = pass_q;
    assign oErrCnt        = err_q;
    assign oFirstErrValid = fv_q;
    assign oFirstErrAddr  = fa_q;
    assign oFirstErrX     = fx_q;
    assign oFirstErrY     = fy_q;
    assign oCrc           = crc_q;
endmodule

// File: tb/tb_frame_checker.sv
// Bench for frame_checker: an 8x4 frame with two-cycle memories for compare/CRC/timing,
// and a 9-pixel byte frame for the CRC-16/CCITT-FALSE known answer.
module tb_frame_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    // ---------------- instance A: H=8 V=4 ADDR_W=5 PIX_W=16 RD_LAT=2
    logic        a_rst, a_start, a_en, a_mode;
    logic [15:0] a_exp;
    logic [4:0]  a_addr;
    logic        a_rden;
    logic [15:0] a_dd, a_rd, a_s1d, a_s1r;
    logic        a_busy, a_done, a_pass, a_fv;
    logic [4:0]  a_err, a_fa, a_fx, a_fy;
    logic [15:0] a_crc;
    logic [15:0] dmem [32];
    logic [15:0] rmem [32];

    frame_checker #(.H_ACT(8), .V_ACT(4), .ADDR_W(5), .PIX_W(16), .RD_LAT(2)) dut_a (
        .iClk(clk), .iRst(a_rst), .iStart(a_start), .iEn(a_en), .iMode(a_mode),
        .iExpCrc(a_exp), .oAddr(a_addr), .oRdEn(a_rden), .iDutData(a_dd), .iRefData(a_rd),
        .oBusy(a_busy), .oDone(a_done), .oPass(a_pass), .oErrCnt(a_err),
        .oFirstErrValid(a_fv), .oFirstErrAddr(a_fa), .oFirstErrX(a_fx), .oFirstErrY(a_fy),
        .oCrc(a_crc));

    // Two-cycle memories; idle cycles return unrelated noise on both buses.
    always @(posedge clk) begin
        a_s1d <= a_rden ? dmem[a_addr] : 16'($urandom);
        a_s1r <= a_rden ? rmem[a_addr] : 16'($urandom);
        a_dd  <= a_s1d;
        a_rd  <= a_s1r;
    end

    // ---------------- instance B: H=9 V=1 ADDR_W=4 PIX_W=8 RD_LAT=1
    logic        b_rst, b_start, b_en, b_mode;
    logic [15:0] b_exp;
    logic [3:0]  b_addr;
    logic        b_rden;
    logic [7:0]  b_dd, b_rd;
    logic        b_busy, b_done, b_pass, b_fv;
    logic [3:0]  b_err, b_fa, b_fx, b_fy;
    logic [15:0] b_crc;

    frame_checker #(.H_ACT(9), .V_ACT(1), .ADDR_W(4), .PIX_W(8), .RD_LAT(1)) dut_b (
        .iClk(clk), .iRst(b_rst), .iStart(b_start), .iEn(b_en), .iMode(b_mode),
        .iExpCrc(b_exp), .oAddr(b_addr), .oRdEn(b_rden), .iDutData(b_dd), .iRefData(b_rd),
        .oBusy(b_busy), .oDone(b_done), .oPass(b_pass), .oErrCnt(b_err),
        .oFirstErrValid(b_fv), .oFirstErrAddr(b_fa), .oFirstErrX(b_fx), .oFirstErrY(b_fy),
        .oCrc(b_crc));

    always @(posedge clk) begin
        b_dd <= b_rden ? 8'(8'h31 + {4'h0, b_addr}) : 8'($urandom);
        b_rd <= 8'($urandom);
    end

    // ---------------- vectors and scoreboard
    typedef struct {
        logic mode; logic all_bad; int bad0; int bad1; logic thr; logic crc_ok;
        int e_err; logic e_fv; int e_fa; int e_fx; int e_fy; logic e_pass;
    } case_t;

    typedef struct {
        int err; logic fv; int fa; int fx; int fy; logic pass; logic [15:0] crc;
        int st; logic thr;
    } exp_t;

    case_t tbl [9];
    exp_t  sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    task automatic load_a(input case_t c, output logic [15:0] crc);
        crc = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            dmem[i] = 16'($urandom);
            rmem[i] = c.all_bad ? ~dmem[i] : dmem[i];
            crc = crc_byte(crc, dmem[i][15:8]);
            crc = crc_byte(crc, dmem[i][7:0]);
        end
        if (c.bad0 >= 0) rmem[c.bad0] = dmem[c.bad0] ^ 16'h0100;
        if (c.bad1 >= 0) rmem[c.bad1] = dmem[c.bad1] ^ 16'h0001;
    endtask

    task automatic chk_reset_a();
        chk("rst_addr", 32'(a_addr), 0);
        chk("rst_rden", 32'(a_rden), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_pass", 32'(a_pass), 0);
        chk("rst_err", 32'(a_err), 0);
        chk("rst_fv", 32'(a_fv), 0);
        chk("rst_fa", 32'(a_fa), 0);
        chk("rst_fx", 32'(a_fx), 0);
        chk("rst_fy", 32'(a_fy), 0);
        chk("rst_crc", 32'(a_crc), 32'h0000FFFF);
    endtask

    task automatic run_a(input case_t c, input logic mid_start);
        logic [15:0] model;
        exp_t e;
        int rdcnt, last_rd, done_c;
        logic got;
        @(negedge clk);
        load_a(c, model);
        a_mode  = c.mode;
        a_exp   = c.crc_ok ? model : ~model;
        a_en    = 1'b0;
        a_start = 1'b1;
        e = '{c.e_err, c.e_fv, c.e_fa, c.e_fx, c.e_fy, c.e_pass, model, cyc, c.thr};
        sb.push_back(e);
        rdcnt = 0; last_rd = 0; done_c = 0; got = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 1000 && !got; k++) begin
            a_start = mid_start && (k == 5);
            a_en    = c.thr ? ((cyc % 4) == 0) : 1'b1;
            #1;
            if (a_rden) begin rdcnt++; last_rd = cyc; end
            if (a_done) begin got = 1'b1; done_c = cyc; end
            if (!got) @(negedge clk);
        end
        a_start = 1'b0;
        if (!got) begin
            chk("a_done_timeout", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("a_err", 32'(a_err), 32'(e.err));
        chk("a_fv", 32'(a_fv), 32'(e.fv));
        chk("a_first_addr", 32'(a_fa), 32'(e.fa));
        chk("a_first_x", 32'(a_fx), 32'(e.fx));
        chk("a_first_y", 32'(a_fy), 32'(e.fy));
        chk("a_pass", 32'(a_pass), 32'(e.pass));
        chk("a_crc", 32'(a_crc), 32'(e.crc));
        chk("a_busy_at_done", 32'(a_busy), 0);
        chk("a_rd_count", rdcnt, 32);
        chk("a_done_after_last_rd", done_c - last_rd, 3);
        if (!e.thr) chk("a_done_latency", done_c - e.st, 35);
        // A start coincident with oDone must be ignored.
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        #1;
        chk("a_start_at_done_busy", 32'(a_busy), 0);
        chk("a_pass_hold", 32'(a_pass), 32'(e.pass));
    endtask

    task automatic run_b(input logic [15:0] x, input logic ep);
        int st, done_c;
        logic got;
        @(negedge clk);
        b_mode = 1'b1; b_exp = x; b_start = 1'b1; b_en = 1'b1; st = cyc;
        got = 1'b0; done_c = 0;
        @(negedge clk);
        b_start = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            #1;
            if (b_done) begin got = 1'b1; done_c = cyc; end
            if (!got) @(negedge clk);
        end
        if (!got) begin
            chk("b_done_timeout", 0, 1);
            return;
        end
        chk("b_crc", 32'(b_crc), 32'h000029B1);
        chk("b_pass", 32'(b_pass), 32'(ep));
        chk("b_err_mode1", 32'(b_err), 0);
        chk("b_fv_mode1", 32'(b_fv), 0);
        chk("b_done_latency", done_c - st, 11);
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, -1, -1, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 10, -1, 1'b0, 1'b1, 1, 1'b1, 10, 2, 1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 10, 31, 1'b0, 1'b1, 2, 1'b1, 10, 2, 1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, -1, -1, 1'b0, 1'b1, 31, 1'b1, 0, 0, 0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, -1, -1, 1'b0, 1'b1, 0, 1'b0, 0, 0, 0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, -1, -1, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 10, -1, 1'b1, 1'b1, 1, 1'b1, 10, 2, 1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 31, -1, 1'b0, 1'b1, 1, 1'b1, 31, 7, 3, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 8, -1, 1'b1, 1'b1, 1, 1'b1, 8, 0, 1, 1'b0};

        a_rst = 1'b1; a_start = 1'b0; a_en = 1'b0; a_mode = 1'b0; a_exp = '0;
        b_rst = 1'b1; b_start = 1'b0; b_en = 1'b0; b_mode = 1'b0; b_exp = '0;
        for (int i = 0; i < 32; i++) begin dmem[i] = '0; rmem[i] = '0; end
        repeat (3) @(negedge clk);
        #1;
        chk_reset_a();
        a_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);
        #1;
        chk("a_idle_busy", 32'(a_busy), 0);
        chk("b_rst_crc", 32'(b_crc), 32'h0000FFFF);
        chk("b_rst_busy", 32'(b_busy), 0);

        for (int i = 0; i < 9; i++) run_a(tbl[i], i == 2);

        // Reset in the middle of a run, then a clean rerun.
        begin
            logic [15:0] m;
            logic hit;
            @(negedge clk);
            load_a(tbl[1], m);
            a_mode = 1'b0; a_exp = m; a_start = 1'b1;
            @(negedge clk);
            a_start = 1'b0; a_en = 1'b1; hit = 1'b0;
            for (int k = 0; k < 200 && !hit; k++) begin
                #1;
                if (a_addr == 5'd12) hit = 1'b1;
                else @(negedge clk);
            end
            chk("a_reached_addr12", 32'(hit), 1);
            a_rst = 1'b1;
            #1;
            chk_reset_a();
            @(negedge clk);
            a_rst = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                #1;
                chk("a_post_rst_rden", 32'(a_rden), 0);
                chk("a_post_rst_busy", 32'(a_busy), 0);
            end
            a_en = 1'b0;
            run_a(tbl[1], 1'b0);
        end

        run_b(16'h29B1, 1'b1);
        run_b(16'h0000, 1'b0);

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/frame_checker.md
# frame_checker

Hardware self-check engine for the CNN output path. When started, it scans a frame buffer of H_ACT×V_ACT pixels and compares every DUT pixel against a reference memory in one pass. It reports the mismatch count and the position of the first mismatch, and computes a CRC-16 signature of the DUT frame. It sits beside the RGB565 output buffer on its spare read port and replaces the simulation-only frame compare with an on-chip pass/fail result.

## Interface
- H_ACT, 480, pixels per row
- V_ACT, 272, rows per frame; DEPTH = H_ACT*V_ACT
- ADDR_W, 17, buffer address width; DEPTH ≤ 2^ADDR_W
- PIX_W, 16, pixel width (RGB565); must be a multiple of 8
- RD_LAT, 1, read latency of both memories in cycles (1..4)
- iClk  in  1  system clock
- iRst  in  1  asynchronous, active-high reset
- iStart  in  1  start pulse; sampled only in IDLE
- iEn  in  1  advance enable; a read is issued only in RUN cycles with iEn=1
- iMode  in  1  0 = compare + CRC, 1 = CRC only; latched at start
- iExpCrc  in  16  expected signature, used in mode 1; latched at start
- oAddr  out  ADDR_W  read address, shared by the DUT and reference memories
- oRdEn  out  1  read strobe
- iDutData  in  PIX_W  DUT pixel, valid RD_LAT cycles after oRdEn
- iRefData  in  PIX_W  reference pixel, same timing as iDutData
- oBusy  out  1  high from the start accept edge until oDone
- oDone  out  1  one-cycle pulse when results are final
- oPass  out  1  pass verdict, valid from oDone until the next start
- oErrCnt  out  ADDR_W  mismatch count, saturating at all-ones
- oFirstErrValid  out  1  high if at least one mismatch was found
- oFirstErrAddr  out  ADDR_W  linear address of the first mismatch
- oFirstErrX / oFirstErrY  out  ADDR_W  column and row of the first mismatch
- oCrc  out  16  CRC-16 signature of the DUT pixels

## Operation
- FSM states: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: on iStart=1, latch iMode and iExpCrc, clear oErrCnt, oFirstErr*, and oPass, load CRC with 0xFFFF, reset the address and X/Y counters, then enter RUN. Previous results hold in IDLE until a start is accepted.
- RUN: on each iEn=1 cycle, oRdEn=1 and oAddr = current address; the address increments afterwards. X wraps at H_ACT-1 to 0, incrementing Y. After issuing address DEPTH-1, go to DRAIN.
- Cycles in RUN with iEn=0: oRdEn=0; oAddr holds its value.
- Valid pipeline: a RD_LAT-deep shift register of oRdEn, carrying the matching address, X, and Y. The compare stage acts only on delayed-valid cycles.
- Compare (mode 0): if iDutData != iRefData, increment oErrCnt (saturating). On the first mismatch, capture the address, X, and Y and set oFirstErrValid.
- CRC (both modes): CRC-16/CCITT-FALSE, polynomial 0x1021, initial value 0xFFFF, no reflection, no final XOR. The DUT pixel is fed MSB-first as PIX_W/8 bytes. iRefData is ignored in mode 1.
- DRAIN: wait until the valid pipeline is empty (RD_LAT cycles), then go to DONE.
- DONE: assert oDone for one cycle and go to IDLE.
  - Mode 0: oPass = (oErrCnt==0).
  - Mode 1: oPass = (oCrc==iExpCrc latched).
- iStart outside IDLE is ignored, including an iStart coincident with oDone.
- iRst asserted at any time, including mid-RUN, returns all state to reset values immediately. Reads stop, and a new iStart is required.

## Timing
- Reset values: oAddr=0, oRdEn=0, oBusy=0, oDone=0, oPass=0, oErrCnt=0, oFirstErrValid=0, oFirstErrAddr/X/Y=0, oCrc=0xFFFF; FSM in IDLE.
- iStart is sampled at edge E0. From cycle E0+1: oBusy=1 and the first oRdEn is possible.
- With iEn held at 1: oRdEn is high for exactly DEPTH consecutive cycles (E0+1 … E0+DEPTH), and oDone is high in cycle E0+DEPTH+RD_LAT+1.
- With throttled iEn: oDone comes RD_LAT+1 cycles after the cycle carrying the last read.
- The compare and CRC registers update on the edge that ends the data-valid cycle. All outputs are registered.
- oBusy falls in the same cycle that oDone rises.

## Test plan
- Identical DUT and reference frames, mode 0, iEn=1, defaults: oDone at E0+130562, oPass=1, oErrCnt=0, oFirstErrValid=0.
- Single mismatch at address 1000: oErrCnt=1, oFirstErrAddr=1000, X=40, Y=2, oPass=0. Add a second mismatch at 130559: oErrCnt=2 and the first-error fields are unchanged.
- Small configuration (H_ACT=4, V_ACT=2, ADDR_W=3), all 8 pixels mismatched: oErrCnt saturates at 7, oFirstErrAddr=0.
- CRC mode: PIX_W=8, H_ACT=9, V_ACT=1, pixels 0x31..0x39, iExpCrc=0x29B1 → oCrc=0x29B1 and oPass=1. With iExpCrc=0x0000 → oPass=0.
- iEn pulsed once every 16 cycles, RD_LAT=2: results equal the iEn=1 run, the oRdEn count equals DEPTH, and oDone arrives 3 cycles after the last read.
- iRst pulsed mid-RUN at address 500: all outputs return to reset values at once. iStart during RUN is ignored. A new start then completes normally with correct results.
